// File: rtl/classificador_palavra_musical.sv
// Note-stream word classifier: splits notes into words at rests, classifies each
// word by its suffix, and reports length, word count and a 7-segment digit.
module classificador_palavra_musical #(
    parameter int unsigned       NOTE_W   = 4,
    parameter int unsigned       STEM_LEN = 2,
    parameter logic [NOTE_W-1:0] SUF1_A   = 4'b0110,
    parameter logic [NOTE_W-1:0] SUF1_B   = 4'b1111,
    parameter logic [NOTE_W-1:0] SUF2_AC  = 4'b0001,
    parameter logic [NOTE_W-1:0] SUF2_AV  = 4'b1111,
    parameter logic [NOTE_W-1:0] SUF2_BC  = 4'b0010,
    parameter int unsigned       CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ok,
    input  logic [NOTE_W-1:0] nota,
    output logic              fim,
    output logic [1:0]        tipo,
    output logic              erro,
    output logic [3:0]        tamanho,
    output logic [CNT_W-1:0]  contador,
    output logic [6:0]        display
);

    localparam int unsigned           STEM_CW  = $clog2(STEM_LEN + 1);
    localparam logic [STEM_CW-1:0]    STEM_MAX = STEM_CW'(STEM_LEN);
    localparam logic [3:0]            TAM_MAX  = 4'hF;

    localparam logic [1:0] T_NULL = 2'b00;
    localparam logic [1:0] T_ADJ  = 2'b01;
    localparam logic [1:0] T_COMP = 2'b10;
    localparam logic [1:0] T_ADV  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_STEM, S_SA, S_SB, S_SC, S_SV, S_ERRW, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               ok_q;
    logic [STEM_CW-1:0] cnt_q, cnt_d;
    logic               fim_q, fim_d;
    logic [1:0]         tipo_q, tipo_d;
    logic               erro_q, erro_d;
    logic [3:0]         tam_q, tam_d;
    logic [CNT_W-1:0]   ctr_q, ctr_d;

    logic       acc, rest;
    logic [3:0] tam_inc;
    logic       fin;
    logic [1:0] fin_tipo;
    logic       fin_erro;

    assign acc     = ok & ~ok_q;
    assign rest    = (nota[NOTE_W-2:0] == '0);
    assign tam_inc = (tam_q == TAM_MAX) ? tam_q : tam_q + 4'd1;

    // Next-state and registered-output logic; every change is qualified by acc
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fim_d    = fim_q;
        tipo_d   = tipo_q;
        erro_d   = erro_q;
        tam_d    = tam_q;
        ctr_d    = ctr_q;
        fin      = 1'b0;
        fin_tipo = T_NULL;
        fin_erro = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (acc && !rest) begin
                    state_d = S_STEM;
                    cnt_d   = STEM_CW'(1);
                    tam_d   = 4'd1;
                    fim_d   = 1'b0;
                    tipo_d  = T_NULL;
                    erro_d  = 1'b0;
                end
            end
            S_STEM: begin
                if (acc) begin
                    if (rest) begin
                        fin      = 1'b1;
                        fin_erro = 1'b1;
                    end else begin
                        tam_d = tam_inc;
                        if (cnt_q < STEM_MAX) cnt_d   = cnt_q + STEM_CW'(1);
                        else if (nota == SUF1_A) state_d = S_SA;
                        else if (nota == SUF1_B) state_d = S_SB;
                        else                     state_d = S_ERRW;
                    end
                end
            end
            S_SA: begin
                if (acc) begin
                    if (rest) begin
                        fin      = 1'b1;
                        fin_tipo = T_ADJ;
                    end else begin
                        tam_d = tam_inc;
                        if (nota == SUF2_AC)      state_d = S_SC;
                        else if (nota == SUF2_AV) state_d = S_SV;
                        else                      state_d = S_ERRW;
                    end
                end
            end
            S_SB: begin
                if (acc) begin
                    if (rest) begin
                        fin      = 1'b1;
                        fin_tipo = T_ADJ;
                    end else begin
                        tam_d   = tam_inc;
                        state_d = (nota == SUF2_BC) ? S_SC : S_ERRW;
                    end
                end
            end
            S_SC, S_SV: begin
                if (acc) begin
                    if (rest) begin
                        fin      = 1'b1;
                        fin_tipo = (state_q == S_SC) ? T_COMP : T_ADV;
                    end else begin
                        tam_d   = tam_inc;
                        state_d = S_ERRW;
                    end
                end
            end
            S_ERRW: begin
                if (acc) begin
                    if (rest) begin
                        fin      = 1'b1;
                        fin_erro = 1'b1;
                    end else begin
                        tam_d = tam_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            state_d = S_DONE;
            fim_d   = 1'b1;
            tipo_d  = fin_tipo;
            erro_d  = fin_erro;
            ctr_d   = ctr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ok_q    <= 1'b1;
            cnt_q   <= '0;
            fim_q   <= 1'b0;
            tipo_q  <= T_NULL;
            erro_q  <= 1'b0;
            tam_q   <= '0;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            ok_q    <= ok;
            cnt_q   <= cnt_d;
            fim_q   <= fim_d;
            tipo_q  <= tipo_d;
            erro_q  <= erro_d;
            tam_q   <= tam_d;
            ctr_q   <= ctr_d;
        end
    end

    // Active-low segment decode {g,f,e,d,c,b,a}
    always_comb begin
        display = 7'b0111111;
        if (fim_q) begin
            if (erro_q) begin
                display = 7'b0000110;
            end else begin
                case (tipo_q)
                    2'd0:    display = 7'b1000000;
                    2'd1:    display = 7'b1111001;
                    2'd2:    display = 7'b0100100;
                    default: display = 7'b0110000;
                endcase
            end
        end
    end

    assign fim      = fim_q;
    assign tipo     = tipo_q;
    assign erro     = erro_q;
    assign tamanho  = tam_q;
    assign contador = ctr_q;

endmodule

// File: tb/tb_classificador_palavra_musical.sv
// Randomized and directed bench for classificador_palavra_musical against a
// word-level reference model (collect notes, classify the whole word at its rest).
module tb_classificador_palavra_musical;

    localparam int unsigned STEM_LEN = 2;
    localparam logic [3:0] SA  = 4'b0110;
    localparam logic [3:0] SB  = 4'b1111;
    localparam logic [3:0] SAC = 4'b0001;
    localparam logic [3:0] SAV = 4'b1111;
    localparam logic [3:0] SBC = 4'b0010;

    logic       clk = 1'b0;
    logic       reset;
    logic       ok;
    logic [3:0] nota;
    logic       fim;
    logic [1:0] tipo;
    logic       erro;
    logic [3:0] tamanho;
    logic [7:0] contador;
    logic [6:0] display;

    classificador_palavra_musical dut (
        .clk      (clk),
        .reset    (reset),
        .ok       (ok),
        .nota     (nota),
        .fim      (fim),
        .tipo     (tipo),
        .erro     (erro),
        .tamanho  (tamanho),
        .contador (contador),
        .display  (display)
    );

    always #5 clk = ~clk;

    bit         in_word;
    logic [3:0] word_q[$];
    logic       m_fim;
    logic [1:0] m_tipo;
    logic       m_erro;
    logic [3:0] m_tam;
    logic [7:0] m_cnt;
    int         n_chk = 0;
    int         n_pass = 0;

    logic [29:0] got;
    assign got = {fim, tipo, erro, tamanho, contador, display};

    function automatic logic [6:0] disp_of(input logic f, input logic e, input logic [1:0] t);
        logic [6:0] digits [4];
        digits = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
        if (!f) return 7'b0111111;
        if (e)  return 7'b0000110;
        return digits[t];
    endfunction

    function automatic logic [29:0] exp_vec();
        return {m_fim, m_tipo, m_erro, m_tam, m_cnt, disp_of(m_fim, m_erro, m_tipo)};
    endfunction

    task automatic model_reset();
        in_word = 0;
        word_q.delete();
        m_fim = 0; m_tipo = 2'b00; m_erro = 0; m_tam = 4'd0; m_cnt = 8'd0;
    endtask

    // Whole-word classification: STEM_LEN free notes then a suffix from the table
    task automatic model_classify();
        int n = word_q.size();
        m_tipo = 2'b00;
        m_erro = 1;
        if (n == STEM_LEN + 1) begin
            if (word_q[STEM_LEN] == SA || word_q[STEM_LEN] == SB) begin
                m_tipo = 2'b01; m_erro = 0;
            end
        end else if (n == STEM_LEN + 2) begin
            if ((word_q[STEM_LEN] == SA && word_q[STEM_LEN+1] == SAC) ||
                (word_q[STEM_LEN] == SB && word_q[STEM_LEN+1] == SBC)) begin
                m_tipo = 2'b10; m_erro = 0;
            end else if (word_q[STEM_LEN] == SA && word_q[STEM_LEN+1] == SAV) begin
                m_tipo = 2'b11; m_erro = 0;
            end
        end
    endtask

    task automatic model_note(input logic [3:0] n);
        if (n[2:0] == 3'd0) begin
            if (in_word) begin
                model_classify();
                in_word = 0;
                m_fim = 1;
                m_cnt = m_cnt + 8'd1;
            end
        end else begin
            if (!in_word) begin
                in_word = 1;
                word_q.delete();
                m_fim = 0; m_tipo = 2'b00; m_erro = 0;
            end
            word_q.push_back(n);
            m_tam = (word_q.size() > 15) ? 4'd15 : 4'(word_q.size());
        end
    endtask

    // One ok pulse held for 'hold' cycles; nota is scrambled after the accepting edge
    task automatic send(input logic [3:0] n, input int hold);
        @(negedge clk);
        nota = n;
        ok   = 1'b1;
        model_note(n);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            nota = 4'($urandom);
        end
        @(negedge clk);
        ok = 1'b0;
    endtask

    task automatic send_seq(input logic [3:0] ns[$]);
        foreach (ns[i]) send(ns[i], 1);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    function automatic logic [3:0] rnd_note();
        return {1'($urandom_range(0, 1)), 3'($urandom_range(1, 7))};
    endfunction

    task automatic test_reset();
        reset = 1'b0; ok = 1'b1; nota = 4'b0011;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if (got !== exp_vec()) $display("FAIL reset_state got=%h exp=%h", got, exp_vec());
        else n_pass++;
        n_chk++;
        if ({fim, contador, display} !== {1'b0, 8'd0, 7'b0111111})
            $display("FAIL reset_held_ok got=%b/%0d/%b exp=0/0/0111111", fim, contador, display);
        else n_pass++;
        ok = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_adjective();
        send_seq('{4'b0011, 4'b0101, 4'b0110, 4'b0000});
        n_chk++;
        if (got !== exp_vec()) $display("FAIL adj_model got=%h exp=%h", got, exp_vec());
        else n_pass++;
        n_chk++;
        if ({fim, tipo, erro, tamanho, contador, display} !== {1'b1, 2'b01, 1'b0, 4'd3, 8'd1, 7'b1111001})
            $display("FAIL adj_lit got=%b %b %b %0d %0d %b", fim, tipo, erro, tamanho, contador, display);
        else n_pass++;
    endtask

    task automatic test_comp_adverb();
        do_reset(1);
        send_seq('{4'b0011, 4'b0101, 4'b0110, 4'b0001, 4'b0000});
        n_chk++;
        if ({fim, tipo, erro, tamanho} !== {1'b1, 2'b10, 1'b0, 4'd4})
            $display("FAIL comp_a got=%b %b %b %0d exp=1 10 0 4", fim, tipo, erro, tamanho);
        else n_pass++;
        send(4'b0010, 1);
        n_chk++;
        if ({fim, tipo, tamanho} !== {1'b0, 2'b00, 4'd1})
            $display("FAIL fim_clear got=%b %b %0d exp=0 00 1", fim, tipo, tamanho);
        else n_pass++;
        send_seq('{4'b0100, 4'b0110, 4'b1111, 4'b1000});
        n_chk++;
        if ({fim, tipo, erro, contador, display} !== {1'b1, 2'b11, 1'b0, 8'd2, 7'b0110000})
            $display("FAIL adverb got=%b %b %b %0d %b", fim, tipo, erro, contador, display);
        else n_pass++;
        send_seq('{4'b0011, 4'b0101, 4'b1111, 4'b0010, 4'b0000});
        n_chk++;
        if (got !== exp_vec() || tipo !== 2'b10)
            $display("FAIL comp_b got=%h exp=%h", got, exp_vec());
        else n_pass++;
    endtask

    task automatic test_error_absorb();
        send_seq('{4'b0011, 4'b0101, 4'b0011, 4'b0110, 4'b0001});
        n_chk++;
        if (fim !== 1'b0 || tamanho !== 4'd5)
            $display("FAIL err_mid got=%b/%0d exp=0/5", fim, tamanho);
        else n_pass++;
        send(4'b0000, 1);
        n_chk++;
        if ({fim, erro, tipo, tamanho, display} !== {1'b1, 1'b1, 2'b00, 4'd5, 7'b0000110})
            $display("FAIL err_end got=%b %b %b %0d %b", fim, erro, tipo, tamanho, display);
        else n_pass++;
        n_chk++;
        if (got !== exp_vec()) $display("FAIL err_model got=%h exp=%h", got, exp_vec());
        else n_pass++;
    endtask

    task automatic test_early_rest();
        logic [7:0] saved;
        send_seq('{4'b0011, 4'b0000});
        n_chk++;
        if ({fim, erro, tipo, tamanho} !== {1'b1, 1'b1, 2'b00, 4'd1})
            $display("FAIL early_rest got=%b %b %b %0d exp=1 1 00 1", fim, erro, tipo, tamanho);
        else n_pass++;
        saved = m_cnt;
        send_seq('{4'b0000, 4'b1000});
        n_chk++;
        if (contador !== saved || got !== exp_vec())
            $display("FAIL lead_rests got=%h exp=%h", got, exp_vec());
        else n_pass++;
    endtask

    task automatic test_reset_midword();
        send_seq('{4'b0011, 4'b0101});
        do_reset(1);
        @(negedge clk);
        n_chk++;
        if (got !== exp_vec()) $display("FAIL midword_rst got=%h exp=%h", got, exp_vec());
        else n_pass++;
        send_seq('{4'b0001, 4'b0001, 4'b0110, 4'b0000});
        n_chk++;
        if ({fim, tipo, erro, contador} !== {1'b1, 2'b01, 1'b0, 8'd1})
            $display("FAIL midword_next got=%b %b %b %0d exp=1 01 0 1", fim, tipo, erro, contador);
        else n_pass++;
    endtask

    // Random words of every shape, enough of them to wrap the word counter
    task automatic test_random();
        for (int w = 0; w < 300; w++) begin
            logic [3:0] q[$];
            int kind = $urandom_range(0, 9);
            int stem = (kind == 0) ? $urandom_range(0, 1) :
                       (kind == 1) ? $urandom_range(3, 18) : STEM_LEN;
            if ($urandom_range(0, 3) == 0) begin
                send({1'($urandom_range(0, 1)), 3'b000}, $urandom_range(1, 3));
                n_chk++;
                if (got !== exp_vec()) $display("FAIL rnd_idle_rest w=%0d got=%h exp=%h", w, got, exp_vec());
                else n_pass++;
            end
            for (int i = 0; i < stem; i++) q.push_back(rnd_note());
            case (kind)
                2: q.push_back(SA);
                3: q.push_back(SB);
                4: begin q.push_back(SA); q.push_back(SAC); end
                5: begin q.push_back(SA); q.push_back(SAV); end
                6: begin q.push_back(SB); q.push_back(SBC); end
                7: for (int i = 0; i < $urandom_range(1, 3); i++) q.push_back(rnd_note());
                8: begin q.push_back(SA); q.push_back(SAC); q.push_back(rnd_note()); end
                9: begin q.push_back(SB); q.push_back(SAV); end
                default: ;
            endcase
            q.push_back({1'($urandom_range(0, 1)), 3'b000});
            foreach (q[i]) begin
                send(q[i], $urandom_range(1, 3));
                n_chk++;
                if (got !== exp_vec()) $display("FAIL rnd w=%0d i=%0d got=%h exp=%h", w, i, got, exp_vec());
                else n_pass++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_adjective();
        test_comp_adverb();
        test_error_absorb();
        test_early_rest();
        test_reset_midword();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
